// File: rtl/register_file_sb_pkg.sv
// regfile_pkg: shared constants, address-width helper and FSM state type for register_file_sb.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic {CLEAR, READY} rf_state_t;
endpackage

// File: rtl/register_file_sb_scoreboard.sv
// reg_scoreboard: per-register pending bits with set-over-clear priority and a transition-tracking count.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  rf_state_t        state,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      pend_cnt
);
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0] cnt_q, cnt_d;
  logic set_v, clr_v, inc, dec;
  assign set_v = state == READY && iss_en && !(ZERO_REG != 0 && iss_addr == '0);
  assign clr_v = state == READY && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  // Only 0->1 and 1->0 edges move the count, so it can never exceed the pending population.
  assign inc = set_v && !pend_q[iss_addr];
  assign dec = clr_v && pend_q[wr_addr] && !(set_v && iss_addr == wr_addr);
  always_comb begin
    pend_d = pend_q;
    if (clr_v) pend_d[wr_addr] = 1'b0;
    if (set_v) pend_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
  assign pending = pend_q;
  assign pend_cnt = cnt_q;
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: integer register file with bypassed async reads, sequential post-reset clear
// and a pending scoreboard for issue/writeback tracking.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_pending,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              busy,
  output logic [AW:0]       pend_cnt
);
  rf_state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] pending;
  logic wr_ok, we;
  assign wr_ok = state_q == READY && wr_en;
  assign we = wr_ok && !rst && !(ZERO_REG != 0 && wr_addr == '0);
  assign busy = state_q == CLEAR;
  always_comb begin
    clr_idx_d = busy ? clr_idx_q + AW'(1) : clr_idx_q;
    state_d = (busy && clr_idx_q == AW'(NREGS-1)) ? READY : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // The array has no reset of its own; the clear FSM zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (busy) regs_q[clr_idx_q] <= '0;
    else if (we) regs_q[wr_addr] <= wr_data;
  end
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0] a;
    logic byp;
    assign a = rd_addr[r*AW +: AW];
    assign byp = wr_ok && wr_addr == a;
    assign rd_data[r*XLEN +: XLEN] = (busy || (ZERO_REG != 0 && a == '0)) ? '0 :
                                     byp ? wr_data : regs_q[a];
    assign rd_pending[r] = !busy && pending[a] && !byp;
  end
  reg_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .state(state_q),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .pending(pending),
    .pend_cnt(pend_cnt)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: table-driven vectors through a scoreboard queue plus hand sequences for clear/reset.
module tb_register_file_sb;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst;
  logic [2*AW-1:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_pending;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  logic busy;
  logic [AW:0] pend_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  register_file_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy(busy), .pend_cnt(pend_cnt)
  );
  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic ie; logic [4:0] ia;
    logic [4:0] r0; logic [4:0] r1;
    logic [31:0] d0; logic [31:0] d1; logic p0; logic p1; logic [5:0] c;
  } vec_t;
  vec_t tbl[18];
  vec_t exp_q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic count_busy(input string nm, input bit drop_drive);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else begin
        n++;
        chk({nm, "_rd_zero"}, rd_data, 64'd0);
        chk({nm, "_rd_pend_zero"}, 64'(rd_pending), 64'd0);
      end
    end
    if (drop_drive) begin
      wr_en = 0;
      iss_en = 0;
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'd32);
  endtask
  initial begin
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; iss_en = 0; iss_addr = '0; rd_addr = '0;
    tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[2]  = '{1, 0, 32'h1234, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 7, 5, 0, 32'hDEADBEEF, 1, 0, 1};
    tbl[6]  = '{1, 7, 32'h77, 0, 0, 7, 5, 32'h77, 32'hDEADBEEF, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 7, 7, 32'h77, 32'h77, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 9, 9, 7, 0, 32'h77, 0, 0, 0};
    tbl[9]  = '{1, 9, 32'h99, 1, 9, 9, 9, 32'h99, 32'h99, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 9, 7, 32'h99, 32'h77, 1, 0, 1};
    tbl[11] = '{1, 9, 32'hAA, 1, 3, 3, 9, 0, 32'hAA, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 3, 9, 0, 32'hAA, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 0, 1};
    tbl[16] = '{1, 12, 32'hC, 0, 0, 3, 12, 0, 32'hC, 1, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 12, 3, 32'hC, 0, 0, 1, 1};
    @(posedge clk); #1;
    chk("reset_busy", 64'(busy), 64'd1);
    chk("reset_pend_cnt", 64'(pend_cnt), 64'd0);
    rst = 0;
    count_busy("clear1", 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i+1), 5'(2*i)};
      #1;
      chk($sformatf("clear_reg_pair%0d", i), rd_data, 64'd0);
    end
    chk("clear_pend_cnt", 64'(pend_cnt), 64'd0);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia; rd_addr = {tbl[i].r1, tbl[i].r0};
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vec%0d_queue: got empty expected entry", i);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("vec%0d_d0", i), 64'(rd_data[31:0]), 64'(e.d0));
        chk($sformatf("vec%0d_d1", i), 64'(rd_data[63:32]), 64'(e.d1));
        chk($sformatf("vec%0d_p0", i), 64'(rd_pending[0]), 64'(e.p0));
        chk($sformatf("vec%0d_p1", i), 64'(rd_pending[1]), 64'(e.p1));
        chk($sformatf("vec%0d_cnt", i), 64'(pend_cnt), 64'(e.c));
      end
    end
    @(posedge clk); #1;
    rst = 1; wr_en = 1; wr_addr = 7; wr_data = 32'hFFFF; iss_en = 1; iss_addr = 4; rd_addr = {5'd7, 5'd7};
    @(posedge clk); #1;
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("midclear_busy", 64'(busy), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    count_busy("clear2", 1);
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("reclear_regs_5_7", rd_data, 64'd0);
    chk("reclear_pend_cnt", 64'(pend_cnt), 64'd0);
    rd_addr = {5'd4, 5'd3};
    #1;
    chk("reclear_pending_3_4", 64'(rd_pending), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor of the core's integer register file. Provides NRD asynchronous read ports with same-cycle write-to-read bypass, one synchronous write port, and a per-register pending scoreboard for the pipelined core.
After reset, a sequential clear FSM zeroes the array. The block sits between decode (reads, issue marking) and writeback (ALU/load result).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (power of 2, >=2)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW], AW=$clog2(NREGS)
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_pending  out  NRD  1 = port i register has an outstanding write
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data (resultadoALU path)
iss_en  in  1  issue marks destination pending
iss_addr  in  AW  issued destination
busy  out  1  1 while clear FSM runs; decode must stall
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
- FSM states: CLEAR, READY. rst=1 at a posedge -> CLEAR, clr_idx=0, all pending=0, pend_cnt=0, busy=1. These are the reset values.
- CLEAR: each cycle writes 0 to reg[clr_idx] and clr_idx++. When clr_idx==NREGS-1 is written -> READY next cycle. busy=1 for exactly NREGS cycles after rst deasserts.
- rst asserted mid-CLEAR restarts from clr_idx=0. rst in READY also re-enters CLEAR; array contents are then re-cleared.
- During CLEAR: rd_data=0, rd_pending=0, wr_en and iss_en ignored.
- READY write: if wr_en && !(ZERO_REG && wr_addr==0), reg[wr_addr] <= wr_data at posedge.
- Read (combinational, zero latency), in priority order:
  - ZERO_REG && addr==0 -> 0
  - wr_en && wr_addr==addr -> wr_data (bypass)
  - otherwise reg[addr]
- Scoreboard, one pending bit per register, READY only:
  - iss_en sets pending[iss_addr]
  - wr_en clears pending[wr_addr]
  - Same address in the same cycle: set wins, because the new in-flight producer supersedes.
  - Address 0 is ignored when ZERO_REG=1.
- rd_pending[i] = pending[rd_addr[i]] & ~(wr_en && wr_addr==rd_addr[i]). The bypass satisfies the dependency in that cycle.
- pend_cnt tracks 0->1 and 1->0 transitions only:
  - +1 when an issue hits a non-pending register
  - -1 when a write clears a pending register (no set on the same address)
  - Both on different registers in one cycle: net 0
  - Re-issue to an already-pending register, or a write to a non-pending register: no change
  - Range 0..NREGS-ZERO_REG; never wraps.
- All outputs are driven (no X) from the first cycle after rst.

Decomposition:
- Package regfile_pkg holds:
  - Default XLEN/NREGS constants
  - AW function/localparam
  - typedef enum logic {CLEAR, READY} rf_state_t
- Sub-module reg_scoreboard holds the pending vector, pend_cnt and the set/clear priority. It takes clk, rst, state, iss_*, wr_* and exposes the pending vector and pend_cnt.
- Top module holds the array, clear FSM, read/bypass muxes.

Test Plan:
1. Pulse rst 1 cycle -> busy=1 for 32 cycles then 0; all 32 regs read 0; pend_cnt=0.
2. READY: wr_en, addr 5, data 0xDEADBEEF. In the same cycle rd_addr[0]=5 reads 0xDEADBEEF (bypass); next cycle still reads it with wr_en=0.
3. wr_en, addr 0, data 0x1234 with ZERO_REG=1 -> read of addr 0 returns 0 in that cycle and after.
4. iss_en addr 7 -> next cycle rd_pending=1 on port reading 7, pend_cnt=1.
   - wr_en addr 7 -> rd_pending=0 in that cycle (bypass) and pend_cnt=0 after.
5. Same cycle iss_en addr 9 and wr_en addr 9 (9 pending) -> 9 stays pending, pend_cnt unchanged.
   - Same cycle iss addr 3 and wr addr 9 -> pend_cnt net 0.
6. Reassert rst at clear cycle 10 -> busy stays 1 for 32 more cycles; wr_en during CLEAR has no effect (reads 0 after).
